// File: rtl/morse_decoder_if.sv
// morse_decoder_if: symbol stream in, decoded letter/status/statistics out
interface morse_decoder_if #(parameter int LetterCountWidth = 8);
  logic [1:0] Morse;
  logic SymValid;
  logic [2:0] Letter;
  logic LetterValid;
  logic Error;
  logic [3:0] OutState;
  logic [LetterCountWidth-1:0] LetterCount;
  logic [LetterCountWidth-1:0] ErrCount;
  modport master (output Morse, SymValid, input Letter, LetterValid, Error, OutState, LetterCount, ErrCount);
  modport slave (input Morse, SymValid, output Letter, LetterValid, Error, OutState, LetterCount, ErrCount);
endinterface

// File: rtl/morse_decoder.sv
// morse_decoder: symbol-trie decoder for H/E/L/O with pulse outputs and saturating counters
module morse_decoder #(parameter int LetterCountWidth = 8) (
  input logic Clock,
  input logic Resetn,
  morse_decoder_if.slave bus
);
  localparam logic [3:0] S_IDLE = 4'h0, S_D = 4'h1, S_DD = 4'h2, S_DDD = 4'h3, S_DDDD = 4'h4;
  localparam logic [3:0] S_DA = 4'h5, S_DAD = 4'h6, S_DADD = 4'h7;
  localparam logic [3:0] S_A = 4'h8, S_AA = 4'h9, S_AAA = 4'hA, S_ERR = 4'hF;
  localparam logic [2:0] L_H = 3'd0, L_E = 3'd1, L_L = 3'd2, L_O = 3'd3, L_BLANK = 3'd4;
  localparam logic [LetterCountWidth-1:0] ONE = 1;
  logic [3:0] state, nxt;
  logic emit, err;
  logic [2:0] code;
  assign bus.OutState = state;
  // next state plus letter/error decision for the sampled symbol; unused codes fall back to Idle
  always_comb begin
    nxt = state;
    emit = 1'b0;
    err = 1'b0;
    code = L_BLANK;
    if (state > S_AAA && state < S_ERR) nxt = S_IDLE;
    else if (bus.SymValid)
      case (bus.Morse)
        2'd0: begin
          nxt = S_IDLE;
          case (state)
            S_IDLE: ;
            S_D: begin emit = 1'b1; code = L_E; end
            S_DDDD: begin emit = 1'b1; code = L_H; end
            S_DADD: begin emit = 1'b1; code = L_L; end
            S_AAA: begin emit = 1'b1; code = L_O; end
            default: err = 1'b1;
          endcase
        end
        2'd1:
          case (state)
            S_IDLE: nxt = S_D;
            S_D: nxt = S_DD;
            S_DD: nxt = S_DDD;
            S_DDD: nxt = S_DDDD;
            S_DA: nxt = S_DAD;
            S_DAD: nxt = S_DADD;
            default: nxt = S_ERR;
          endcase
        2'd2:
          case (state)
            S_IDLE: nxt = S_A;
            S_D: nxt = S_DA;
            S_A: nxt = S_AA;
            S_AA: nxt = S_AAA;
            default: nxt = S_ERR;
          endcase
        default: nxt = S_ERR;
      endcase
  end
  // register state, one-cycle pulses, held letter and saturating counters
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
      bus.Letter <= L_BLANK;
      bus.LetterValid <= 1'b0;
      bus.Error <= 1'b0;
      bus.LetterCount <= '0;
      bus.ErrCount <= '0;
    end else begin
      state <= nxt;
      bus.LetterValid <= emit;
      bus.Error <= err;
      if (emit || err) bus.Letter <= code;
      if (emit && !(&bus.LetterCount)) bus.LetterCount <= bus.LetterCount + ONE;
      if (err && !(&bus.ErrCount)) bus.ErrCount <= bus.ErrCount + ONE;
    end
  end
endmodule
